// File: rtl/mul_pkg.sv
// Shared definitions for the iterative ARMv4 MUL/MLA multiplier.
//   mul_state_t : controller state encoding (IDLE, CALC, DONE)
//   MUL_WIDTH   : default operand/result width
//   MUL_BPC     : default multiplier bits retired per CALC cycle
//   MUL_STEPS   : CALC cycles per operation at the defaults
//   MUL_CNT_W   : step counter width at the defaults
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_BPC   = 2;
  localparam int MUL_STEPS = MUL_WIDTH / MUL_BPC;
  localparam int MUL_CNT_W = $clog2(MUL_STEPS + 1);

endpackage

// File: rtl/multiply_digit_step.sv
// One shift-add step of the multiplier: adds multiplicand * digit to the
// running accumulator, keeping only the low WIDTH bits.
//   accum  : running partial sum
//   mcand  : multiplicand, already shifted into position for this digit
//   digit  : low BPC bits of the multiplier
//   sum    : accum + mcand*digit, truncated to WIDTH
module multiply_digit_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int BPC   = MUL_BPC
) (
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] mcand,
  input  logic [BPC-1:0]   digit,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] digit_ext;

  assign digit_ext = WIDTH'(digit);

  // Everything is WIDTH bits wide, so overflow past the top bit is dropped;
  // that is exactly the low-half product MUL/MLA need.
  assign sum = accum + (mcand * digit_ext);

endmodule

// File: rtl/multiply_unit.sv
// Iterative shift-add multiplier for ARMv4 MUL/MLA, fed by the register
// file read ports and writing back through its write port.
//   clk, rst_n       : clock (rising edge), async active-low reset
//   start, abort     : request (sampled in IDLE/DONE), flush (top priority)
//   accumulate       : 1 = MLA (add acc), 0 = MUL
//   op_a, op_b, acc  : multiplicand (Rm), multiplier (Rs), addend (Rn)
//   rd_in            : destination register index
//   busy             : high while in CALC
//   done             : one-cycle result-valid pulse
//   result           : low WIDTH bits of op_a*op_b (+acc)
//   rd_out           : destination index for the completed operation
//   wrt_ena_out      : register-file write strobe (same as done)
//   flag_n, flag_z   : sign / zero of result, valid with done
//
// state | meaning
// IDLE  | waiting for start
// CALC  | retiring BITS_PER_CYCLE multiplier bits per cycle
// DONE  | result valid for one cycle; start here chains the next op
module multiply_unit
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = MUL_BPC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out,
  output logic             wrt_ena_out,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS);

  mul_state_t state, state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] step_sum;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [3:0]       rd_q;
  logic             accept;
  logic             finish;
  logic             calc_en;

  multiply_digit_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_step (
    .accum (accum),
    .mcand (mcand),
    .digit (mplier[BITS_PER_CYCLE-1:0]),
    .sum   (step_sum)
  );

  assign count_inc = count + CNT_W'(1);
  assign calc_en   = (state == CALC) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = CALC;
          end
        end
        CALC: begin
          if (count_inc == CNT_LAST) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The destination index is held privately until completion so rd_out,
  // like result, only changes when an operation actually finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      accum  <= '0;
      count  <= '0;
      rd_q   <= '0;
      result <= '0;
      rd_out <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else if (accept) begin
      mcand  <= op_a;
      mplier <= op_b;
      accum  <= accumulate ? acc : '0;
      count  <= '0;
      rd_q   <= rd_in;
    end else if (calc_en) begin
      accum  <= step_sum;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      count  <= count_inc;
      if (finish) begin
        result <= step_sum;
        rd_out <= rd_q;
        flag_n <= step_sum[WIDTH-1];
        flag_z <= (step_sum == '0);
      end
    end
  end

  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign wrt_ena_out = done;

endmodule

// File: tb/tb_multiply_unit.sv
module tb_multiply_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        accumulate = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] acc = '0;
  logic [3:0]  rd_in = '0;

  logic        busy, done, wrt_ena_out, flag_n, flag_z;
  logic [31:0] result;
  logic [3:0]  rd_out;

  logic        busy1, done1, we1, fn1, fz1;
  logic [31:0] result1;
  logic [3:0]  rd1;

  logic        busy4, done4, we4, fn4, fz4;
  logic [31:0] result4;
  logic [3:0]  rd4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multiply_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .accumulate(accumulate), .op_a(op_a), .op_b(op_b), .acc(acc),
    .rd_in(rd_in), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .wrt_ena_out(wrt_ena_out), .flag_n(flag_n),
    .flag_z(flag_z)
  );

  multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .accumulate(accumulate), .op_a(op_a), .op_b(op_b), .acc(acc),
    .rd_in(rd_in), .busy(busy1), .done(done1), .result(result1),
    .rd_out(rd1), .wrt_ena_out(we1), .flag_n(fn1), .flag_z(fz1)
  );

  multiply_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .accumulate(accumulate), .op_a(op_a), .op_b(op_b), .acc(acc),
    .rd_in(rd_in), .busy(busy4), .done(done4), .result(result4),
    .rd_out(rd4), .wrt_ena_out(we4), .flag_n(fn4), .flag_z(fz4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; lat = edges until done is seen,
  // bcnt = busy samples including the one taken right after accept.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic mla, input logic [3:0] rd,
                       input logic [31:0] exp_r, input logic exp_n, input logic exp_z);
    int lat, bc;
    op_a = a; op_b = b; acc = c; accumulate = mla; rd_in = rd;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    chk({tag, ".lat"}, 64'(lat), 64'd16);
    chk({tag, ".busy"}, 64'(bc), 64'd16);
    chk({tag, ".res"}, 64'(result), 64'(exp_r));
    chk({tag, ".rd"}, 64'(rd_out), 64'(rd));
    chk({tag, ".n"}, 64'(flag_n), 64'(exp_n));
    chk({tag, ".z"}, 64'(flag_z), 64'(exp_z));
    chk({tag, ".we"}, 64'(wrt_ena_out), 64'd1);
    tick();
    chk({tag, ".pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bc, cnt, l1, l2, l4;
    logic [31:0] r1, r2, r4;

    #2;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.we", 64'(wrt_ena_out), 64'd0);
    chk("rst.res", 64'(result), 64'd0);
    chk("rst.rd", 64'(rd_out), 64'd0);
    chk("rst.flags", 64'({flag_n, flag_z}), 64'd0);
    #20 rst_n = 1'b1;
    tick();

    do_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 4'd3, 32'd42, 1'b0, 1'b0);
    do_op("mla", 32'd3, 32'd5, 32'd10, 1'b1, 4'd4, 32'd25, 1'b0, 1'b0);
    do_op("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 4'd5, 32'd1, 1'b0, 1'b0);
    do_op("neg", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd6, 32'h8000_0000, 1'b1, 1'b0);
    do_op("zero", 32'd0, 32'h1234_5678, 32'h0000_DEAD, 1'b0, 4'd7, 32'd0, 1'b0, 1'b1);

    // start held through CALC, then chained from the DONE cycle
    op_a = 32'd4; op_b = 32'd5; acc = 32'd0; accumulate = 1'b0; rd_in = 4'd1;
    start = 1'b1;
    tick();
    wait_done(lat, bc);
    chk("b2b.lat1", 64'(lat), 64'd16);
    chk("b2b.res1", 64'(result), 64'd20);
    op_a = 32'd2; op_b = 32'd9; rd_in = 4'd2;
    tick();
    start = 1'b0;
    chk("b2b.busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    chk("b2b.lat2", 64'(lat), 64'd16);
    chk("b2b.res2", 64'(result), 64'd18);
    chk("b2b.rd2", 64'(rd_out), 64'd2);
    tick();
    chk("b2b.pulse", 64'(done), 64'd0);

    // abort at CALC count 5
    op_a = 32'd100; op_b = 32'd3; rd_in = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || wrt_ena_out) cnt++;
    end
    chk("abort.nodone", 64'(cnt), 64'd0);
    chk("abort.hold", 64'(result), 64'd18);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa.busy", 64'(busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("sa.idle", 64'(cnt), 64'd0);
    chk("sa.hold", 64'(result), 64'd18);

    // reset dropped mid-operation
    do_op("neg2", 32'hC000_0000, 32'd1, 32'd0, 1'b0, 4'd9, 32'hC000_0000, 1'b1, 1'b0);
    op_a = 32'd7; op_b = 32'd6; rd_in = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("rmid.pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid.busy", 64'(busy), 64'd0);
    chk("rmid.res", 64'(result), 64'd0);
    chk("rmid.rd", 64'(rd_out), 64'd0);
    chk("rmid.n", 64'(flag_n), 64'd0);
    chk("rmid.done", 64'(done), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    // BITS_PER_CYCLE sweep: 1, 2, 4 run the same 7*6 in parallel
    op_a = 32'd7; op_b = 32'd6; acc = 32'd0; accumulate = 1'b0; rd_in = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    l1 = 0; l2 = 0; l4 = 0; r1 = '0; r2 = '0; r4 = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done1 && l1 == 0) begin l1 = i; r1 = result1; end
      if (done  && l2 == 0) begin l2 = i; r2 = result;  end
      if (done4 && l4 == 0) begin l4 = i; r4 = result4; end
    end
    chk("bpc1.lat", 64'(l1), 64'd32);
    chk("bpc1.res", 64'(r1), 64'd42);
    chk("bpc2.lat", 64'(l2), 64'd16);
    chk("bpc2.res", 64'(r2), 64'd42);
    chk("bpc4.lat", 64'(l4), 64'd8);
    chk("bpc4.res", 64'(r4), 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
